spi_quad_pixel_rx: RTL and testbench
====================================

// Module: spi_quad_pixel_rx
// PURPOSE
// - Main-FPGA receiver for the 4-line pixel SPI link driven by the peripheral camera FPGA.
// - Synchronizes dclk/cs/data/hsync/vsync, deserializes one 8-bit pixel per data line, and emits pixels in line order.
// - Regenerates hcount/vcount and feeds the depth pipeline through a valid/ready stream with a 2-packet buffer.
// PARAMETERS
// DATA_WIDTH   8    bits per line per packet (pixel width)
// LINES        4    parallel data lines = pixels per packet
// H_ACTIVE     640  pixels per row; hcount wraps here
// V_ACTIVE     360  rows per frame; vcount wraps here
// SYNC_STAGES  2    flops in each input synchronizer
// PORTS
// clk_in          in   1                 system clock (100 MHz)
// rst_in          in   1                 synchronous, active-low reset
// dclk_in         in   1                 SPI data clock, async to clk_in
// cs_in           in   1                 chip select, active-low, async
// data_in         in   LINES             SPI data lines, async; line i carries pixel i
// hsync_in        in   1                 row sync from sender, async
// vsync_in        in   1                 frame sync from sender, async
// pixel_out       out  DATA_WIDTH        pixel value
// hcount_out      out  $clog2(H_ACTIVE)  column of pixel_out
// vcount_out      out  $clog2(V_ACTIVE)  row of pixel_out
// pixel_valid_out out  1                 pixel_out/hcount_out/vcount_out valid
// pixel_ready_in  in   1                 downstream accepts when valid&&ready
// frame_start_out out  1                 high with first pixel after a vsync rising edge
// overflow_out    out  1                 sticky: packet dropped, buffer full
// short_pkt_out   out  1                 1-cycle pulse: cs released with bit count != DATA_WIDTH
// BEHAVIOUR
// - Reset (rst_in==0 at clk_in edge): all outputs 0; synchronizers, shift regs, bit counter, buffer, h/v counters cleared. Mid-packet reset discards the packet.
// - Inputs pass SYNC_STAGES flops; edges detected on synchronized values. Required: dclk high and low phases >= SYNC_STAGES+1 clk_in cycles.
// - RX FSM: IDLE -> SHIFT on synced cs falling edge (bit counter=0). SHIFT: each synced dclk rising edge shifts data_in[i] into shift reg i, MSB first, counter+1.
//   SHIFT -> IDLE on synced cs rising edge; counter==DATA_WIDTH -> commit packet; otherwise discard and pulse short_pkt_out. Bits beyond DATA_WIDTH -> short_pkt_out at cs release, discard.
// - Buffer: 2 packet slots (ping-pong). Commit writes free slot in the cycle after cs rise is detected. Both slots full -> drop new packet, set overflow_out (cleared only by reset).
// - Output: drain oldest slot, line 0 first through line LINES-1. pixel_valid_out rises 1 cycle after commit into an empty buffer. Output regs hold while valid&&!ready.
//   Back-to-back packets stream with no bubble while ready stays high. Commit and drain completing in the same cycle: no drop.
// - Counters: advance on each handshake; hcount wraps H_ACTIVE-1 -> 0 and increments vcount; vcount wraps V_ACTIVE-1 -> 0.
// - Synced vsync rising edge: flush buffer, abort packet in flight, next accepted pixel gets hcount=vcount=0 and frame_start_out=1.
// - Synced hsync rising edge with hcount!=0: next pixel starts at hcount=0, vcount+1 (realigns row on sender drop). hsync with hcount==0: no effect.
// - vsync and cs edge in the same cycle: vsync wins; packet discarded.
// CONFIGURATION
// - SPI_RX_STATS_EN defined: adds outputs pkt_count_out[15:0] (committed packets) and drop_count_out[7:0] (overflow + short drops).
//   Both saturate, no wrap; both reset to 0 on synced vsync rising edge and on reset.
// - SPI_RX_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING
// - Reset: hold rst_in=0 for 4 cycles while toggling dclk -> all outputs 0, no valid.
// - 1 packet, lines {8'hA5,8'h3C,8'hFF,8'h01}, dclk period 6: pixels A5,3C,FF,01 at hcount 0..3, vcount 0, 1 cycle after commit.
// - Ready held low across 3 packets -> first 2 delivered intact after ready=1; 3rd dropped; overflow_out=1; drop_count_out=1 with SPI_RX_STATS_EN.
// - cs released after 5 bits -> short_pkt_out 1-cycle pulse, no pixels emitted, next full packet received correctly.
// - 160 packets (one 640-pixel row) then 1 packet -> hcount 639 -> 0, vcount 0 -> 1.
// - vsync pulse mid-row, then packet 8'h11 x4 -> frame_start_out=1 with hcount=0, vcount=0; pkt_count_out restarts at 1.

Source files
------------

// File: rtl/spi_quad_pixel_rx.sv
// Receiver for the 4-line pixel SPI link. It synchronizes the link, shifts in one pixel per line, and streams the pixels with row/frame counters.
// Optional feature macro: SPI_RX_STATS_EN adds saturating packet/drop counters (pkt_count_out, drop_count_out).
module spi_quad_pixel_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 360,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        dclk_in,
    input  logic                        cs_in,
    input  logic [LINES-1:0]            data_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    output logic [DATA_WIDTH-1:0]       pixel_out,
    output logic [$clog2(H_ACTIVE)-1:0] hcount_out,
    output logic [$clog2(V_ACTIVE)-1:0] vcount_out,
    output logic                        pixel_valid_out,
    input  logic                        pixel_ready_in,
    output logic                        frame_start_out,
    output logic                        overflow_out,
    output logic                        short_pkt_out
`ifdef SPI_RX_STATS_EN
    ,
    output logic [15:0]                 pkt_count_out,
    output logic [7:0]                  drop_count_out
`endif
);

    localparam int HW    = $clog2(H_ACTIVE);
    localparam int VW    = $clog2(V_ACTIVE);
    localparam int IW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW    = $clog2(DATA_WIDTH + 2);
    localparam int NSYNC = LINES + 4;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [NSYNC-1:0] w_async;
    logic [NSYNC-1:0] r_sync [SYNC_STAGES];
    logic [NSYNC-1:0] r_prev;
    logic [NSYNC-1:0] w_cur;
    logic [LINES-1:0] w_data_s;
    logic             w_dclk_rise;
    logic             w_cs_fall;
    logic             w_cs_rise;
    logic             w_hsync_rise;
    logic             w_vsync_rise;

    assign w_async = {vsync_in, hsync_in, cs_in, dclk_in, data_in};

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= w_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_cur        = r_sync[SYNC_STAGES-1];
    assign w_data_s     = w_cur[LINES-1:0];
    assign w_dclk_rise  =  w_cur[LINES]   & ~r_prev[LINES];
    assign w_cs_fall    = ~w_cur[LINES+1] &  r_prev[LINES+1];
    assign w_cs_rise    =  w_cur[LINES+1] & ~r_prev[LINES+1];
    assign w_hsync_rise =  w_cur[LINES+2] & ~r_prev[LINES+2];
    assign w_vsync_rise =  w_cur[LINES+3] & ~r_prev[LINES+3];

    // ------------------------------------------------------------------
    // RX FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    rx_state_t r_state;
    rx_state_t w_state_next;
    logic      w_start;
    logic      w_shift;
    logic      w_done;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_vsync_rise) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_cs_fall) w_state_next = S_SHIFT;
                S_SHIFT: if (w_cs_rise) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // A vsync edge in the same cycle as any cs edge aborts the packet outright.
    always_comb begin
        w_start = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        if (!w_vsync_rise) begin
            case (r_state)
                S_IDLE: begin
                    w_start = w_cs_fall;
                end
                S_SHIFT: begin
                    w_shift = w_dclk_rise & ~w_cs_rise;
                    w_done  = w_cs_rise;
                end
                default: begin
                    w_start = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Deserializer
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_shift [LINES];
    logic [CW-1:0]         r_bitcnt;
    logic                  r_commit_pend;
    logic                  r_short;
    logic                  w_len_ok;

    assign w_len_ok = (r_bitcnt == CW'(DATA_WIDTH));

    // Bit counter saturates one past DATA_WIDTH so long packets stay flagged as bad.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < LINES; i++) begin
                r_shift[i] <= '0;
            end
            r_bitcnt      <= '0;
            r_commit_pend <= 1'b0;
            r_short       <= 1'b0;
        end else begin
            r_commit_pend <= 1'b0;
            r_short       <= 1'b0;
            if (w_start) begin
                r_bitcnt <= '0;
            end else if (w_shift) begin
                for (int i = 0; i < LINES; i++) begin
                    r_shift[i] <= {r_shift[i][DATA_WIDTH-2:0], w_data_s[i]};
                end
                if (r_bitcnt != CW'(DATA_WIDTH + 1)) begin
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
            end
            if (w_done) begin
                r_commit_pend <= w_len_ok;
                r_short       <= ~w_len_ok;
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-slot packet buffer and output drain
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_slot [2][LINES];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [IW-1:0]         r_rd_idx;
    logic                  r_overflow;
    logic                  w_valid;
    logic                  w_fire;
    logic                  w_pop;
    logic                  w_commit_try;
    logic                  w_write;
    logic                  w_drop;

    assign w_valid      = (r_count != 2'd0);
    assign w_fire       = w_valid & pixel_ready_in;
    assign w_pop        = w_fire & (r_rd_idx == IW'(LINES - 1));
    assign w_commit_try = r_commit_pend & ~w_vsync_rise;
    assign w_write      = w_commit_try & ((r_count != 2'd2) | w_pop);
    assign w_drop       = w_commit_try & ~((r_count != 2'd2) | w_pop);

    // When full, a commit coinciding with the last pixel of a slot reuses that slot.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < LINES; i++) begin
                    r_slot[s][i] <= '0;
                end
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_rd_idx   <= '0;
            r_overflow <= 1'b0;
        end else if (w_vsync_rise) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_rd_idx <= '0;
        end else begin
            if (w_write) begin
                for (int i = 0; i < LINES; i++) begin
                    r_slot[r_wr_ptr][i] <= r_shift[i];
                end
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_rd_idx <= '0;
            end else if (w_fire) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
            r_count <= r_count + {1'b0, w_write} - {1'b0, w_pop};
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row / frame position counters
    // ------------------------------------------------------------------
    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [VW-1:0] w_vnext;
    logic          r_frame_pend;

    assign w_vnext = (r_vcount == VW'(V_ACTIVE - 1)) ? '0 : r_vcount + 1'b1;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_frame_pend <= 1'b0;
        end else if (w_vsync_rise) begin
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_frame_pend <= 1'b1;
        end else begin
            if (w_hsync_rise && (r_hcount != '0)) begin
                r_hcount <= '0;
                r_vcount <= w_vnext;
            end else if (w_fire) begin
                if (r_hcount == HW'(H_ACTIVE - 1)) begin
                    r_hcount <= '0;
                    r_vcount <= w_vnext;
                end else begin
                    r_hcount <= r_hcount + 1'b1;
                end
            end
            if (w_fire) begin
                r_frame_pend <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_STATS_EN
    // ------------------------------------------------------------------
    // Saturating link statistics, restarted every frame
    // ------------------------------------------------------------------
    logic [15:0] r_pkt_count;
    logic [7:0]  r_drop_count;
    logic        w_drop_evt;

    assign w_drop_evt = w_drop | (w_done & ~w_len_ok);

    always_ff @(posedge clk_in) begin
        if (!rst_in || w_vsync_rise) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_write && (r_pkt_count != 16'hFFFF)) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (w_drop_evt && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign pkt_count_out  = r_pkt_count;
    assign drop_count_out = r_drop_count;
`endif

    assign pixel_out       = r_slot[r_rd_ptr][r_rd_idx];
    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign pixel_valid_out = w_valid;
    assign frame_start_out = r_frame_pend & w_valid;
    assign overflow_out    = r_overflow;
    assign short_pkt_out   = r_short;

endmodule

// File: tb/tb_spi_quad_pixel_rx.sv
// Scoreboard bench for spi_quad_pixel_rx: randomized SPI packets checked against a pixel-position reference model.
// Builds with or without SPI_RX_STATS_EN.
module tb_spi_quad_pixel_rx;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int HA = 640;
    localparam int VA = 360;

    typedef struct packed {
        logic       fs;
        logic [8:0] v;
        logic [9:0] h;
        logic [7:0] pix;
    } expPix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dclk;
    logic       cs;
    logic [3:0] data;
    logic       hsync;
    logic       vsync;
    logic [7:0] pixelOut;
    logic [9:0] hcountOut;
    logic [8:0] vcountOut;
    logic       pixelValid;
    logic       pixelReady;
    logic       frameStart;
    logic       overflow;
    logic       shortPkt;
`ifdef SPI_RX_STATS_EN
    logic [15:0] pktCount;
    logic [7:0]  dropCount;
    int          modelPkt  = 0;
    int          modelDrop = 0;
`endif

    logic readyMan;
    logic readyRnd;
    bit   randReady;

    expPix_t     expQ[$];
    int unsigned modelPos    = 0;
    bit          modelFsPend = 1'b0;
    int          checks      = 0;
    int          errors      = 0;
    int          shortPulses = 0;
    int          shortHigh   = 0;
    logic        prevShort   = 1'b0;

    always #5 clk = ~clk;

    assign pixelReady = randReady ? readyRnd : readyMan;

    spi_quad_pixel_rx dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .dclk_in         (dclk),
        .cs_in           (cs),
        .data_in         (data),
        .hsync_in        (hsync),
        .vsync_in        (vsync),
        .pixel_out       (pixelOut),
        .hcount_out      (hcountOut),
        .vcount_out      (vcountOut),
        .pixel_valid_out (pixelValid),
        .pixel_ready_in  (pixelReady),
        .frame_start_out (frameStart),
        .overflow_out    (overflow),
        .short_pkt_out   (shortPkt)
`ifdef SPI_RX_STATS_EN
        ,
        .pkt_count_out   (pktCount),
        .drop_count_out  (dropCount)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: pixel position is a linear index within the frame.
    task automatic modelPushPacket(input logic [31:0] pkt);
        expPix_t e;
        for (int i = 0; i < LN; i++) begin
            e.pix = pkt[8*i +: 8];
            e.h   = 10'(modelPos % HA);
            e.v   = 9'((modelPos / HA) % VA);
            e.fs  = modelFsPend;
            modelFsPend = 1'b0;
            expQ.push_back(e);
            modelPos = (modelPos + 1) % (HA * VA);
        end
    endtask

    task automatic pulseSync(input bit isVsync);
        if (isVsync) begin
            modelPos    = 0;
            modelFsPend = 1'b1;
`ifdef SPI_RX_STATS_EN
            modelPkt  = 0;
            modelDrop = 0;
`endif
            vsync = 1'b1;
        end else begin
            if (modelPos % HA != 0) modelPos = ((modelPos / HA + 1) * HA) % (HA * VA);
            hsync = 1'b1;
        end
        cyc(4);
        vsync = 1'b0;
        hsync = 1'b0;
        cyc(4);
    endtask

    // Drives one SPI packet: line i carries byte i of pkt, MSB first.
    task automatic applyStimulus(input logic [31:0] pkt, input int nbits, input int half,
                                 input bit accept, input int gap);
        int bi;
        if (nbits == DW && accept) modelPushPacket(pkt);
`ifdef SPI_RX_STATS_EN
        if (nbits == DW && accept) modelPkt++;
        else modelDrop++;
`endif
        cs = 1'b0;
        cyc(half);
        for (int b = 0; b < nbits; b++) begin
            bi = (b < DW) ? (DW - 1 - b) : 0;
            for (int i = 0; i < LN; i++) data[i] = pkt[8*i + bi];
            cyc(half);
            dclk = 1'b1;
            cyc(half);
            dclk = 1'b0;
        end
        cyc(half);
        cs = 1'b1;
        cyc(gap);
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int k = 0; k < maxCycles && (expQ.size() != 0 || pixelValid); k++) cyc(1);
        checkOutput("drain", expQ.size(), 0);
        cyc(2);
    endtask

    always @(posedge clk) begin
        #1;
        readyRnd = 1'($urandom_range(0, 1));
    end

    // Monitor: pops one expected pixel per handshake.
    always @(negedge clk) begin
        if (pixelValid === 1'b1 && pixelReady === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pixel: got pix=0x%0h h=%0d v=%0d, expected none", pixelOut, hcountOut, vcountOut);
            end else begin
                expPix_t e;
                e = expQ.pop_front();
                checkOutput("pixel{fs,v,h,pix}", {4'b0, frameStart, vcountOut, hcountOut, pixelOut}, {4'b0, e});
            end
        end
        if (shortPkt === 1'b1) shortHigh++;
        if (shortPkt === 1'b1 && prevShort !== 1'b1) shortPulses++;
        prevShort = shortPkt;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst = 1'b0; dclk = 1'b0; cs = 1'b1; data = '0; hsync = 1'b0; vsync = 1'b0;
        readyMan = 1'b1; randReady = 1'b0;

        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 dclk = ~dclk;
            @(negedge clk);
            checkOutput("reset_outputs", {8'b0, pixelValid, frameStart, overflow, shortPkt, pixelOut, hcountOut},
                        32'h0);
            checkOutput("reset_vcount", {23'b0, vcountOut}, 32'h0);
`ifdef SPI_RX_STATS_EN
            checkOutput("reset_stats", {8'b0, pktCount, dropCount}, 32'h0);
`endif
        end
        @(posedge clk);
        #1 rst = 1'b1; dclk = 1'b0;
        cyc(6);

        $display("[TB] single packet A5 3C FF 01");
        applyStimulus(32'h01FF3CA5, 8, 3, 1'b1, 0);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (pixelValid) break;
        end
        checkOutput("valid_latency", lat, 4);
        cyc(4);
        waitDrain(100);

        $display("[TB] short packet then full packet");
        begin
            int p0, h0;
            p0 = shortPulses;
            h0 = shortHigh;
            applyStimulus($urandom(), 5, 3, 1'b0, 8);
            cyc(4);
            checkOutput("short_pulse_count", shortPulses - p0, 1);
            checkOutput("short_pulse_width", shortHigh - h0, 1);
            checkOutput("short_no_pixels", {31'b0, pixelValid}, 0);
        end
        applyStimulus($urandom(), 8, 4, 1'b1, 6);
        waitDrain(100);

        $display("[TB] overflow with ready held low");
        checkOutput("overflow_before", {31'b0, overflow}, 0);
        readyMan = 1'b0;
        applyStimulus($urandom(), 8, 3, 1'b1, 6);
        applyStimulus($urandom(), 8, 3, 1'b1, 6);
        applyStimulus($urandom(), 8, 3, 1'b0, 6);
        cyc(6);
        @(negedge clk);
        checkOutput("overflow_set", {31'b0, overflow}, 1);
        checkOutput("valid_while_stalled", {31'b0, pixelValid}, 1);
`ifdef SPI_RX_STATS_EN
        checkOutput("pkt_count", {16'b0, pktCount}, modelPkt);
        checkOutput("drop_count", {24'b0, dropCount}, modelDrop);
`endif
        cyc(1);
        readyMan = 1'b1;
        waitDrain(100);

        $display("[TB] hsync realign, then hsync at column 0");
        pulseSync(1'b0);
        pulseSync(1'b0);
        applyStimulus($urandom(), 8, 3, 1'b1, 6);
        waitDrain(100);

        $display("[TB] vsync then full row plus one packet");
        pulseSync(1'b1);
        randReady = 1'b1;
        for (int p = 0; p < HA / LN + 1; p++) begin
            applyStimulus($urandom(), 8, $urandom_range(3, 5), 1'b1, $urandom_range(4, 8));
        end
        waitDrain(200);
        randReady = 1'b0;
        readyMan  = 1'b1;

        $display("[TB] vsync mid-row then packet 11x4");
        applyStimulus($urandom(), 8, 3, 1'b1, 6);
        waitDrain(100);
        pulseSync(1'b1);
        applyStimulus(32'h11111111, 8, 3, 1'b1, 6);
        waitDrain(100);
`ifdef SPI_RX_STATS_EN
        checkOutput("pkt_count_restart", {16'b0, pktCount}, modelPkt);
        checkOutput("drop_count_restart", {24'b0, dropCount}, modelDrop);
`endif
        checkOutput("overflow_sticky", {31'b0, overflow}, 1);
        checkOutput("short_total", shortPulses, 1);
        checkOutput("queue_empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
